// File: rtl/gb_bus_if.sv
// rtl/gb_bus_if.sv - DZCPU memory bus bundle between the CPU and the bus responder
// Signals:
//   iAddr    16-bit CPU bus address
//   iData    8-bit CPU write data
//   iWe      CPU write strobe, one cycle per write
//   oData    registered read data, valid one cycle after iAddr
//   oDmaBusy high while OAM DMA is active
// Modports: master (CPU side), slave (responder side).
interface gb_bus_if;
  logic [15:0] iAddr;
  logic [7:0]  iData;
  logic        iWe;
  logic [7:0]  oData;
  logic        oDmaBusy;

  modport master (output iAddr, iData, iWe, input oData, oDmaBusy);
  modport slave  (input iAddr, iData, iWe, output oData, oDmaBusy);
endinterface

// File: rtl/gb_bus_responder.sv
// rtl/gb_bus_responder.sv - DZCPU memory bus target: GB address decode, memories and OAM DMA
// Optional build macro GB_BOOTROM_OVERLAY_EN: a 256-byte boot ROM overlays 0000-00FF
// until a nonzero byte is written to FF50; FF50 then reads FF.
// Ports:
//   iClock  system clock, all state on posedge
//   iReset  asynchronous active-high reset
//   bus     gb_bus_if.slave: iAddr/iData/iWe in, oData (1-cycle registered read) and oDmaBusy out
// Memory arrays (cartridge bank 0, VRAM, WRAM, OAM, HRAM) are not reset; the cartridge
// bank and boot ROM are loaded hierarchically by the surrounding system.
module gb_bus_responder #(
  parameter int DMA_LEN       = 160,
  parameter int DMA_START_DLY = 1
) (
  input logic     iClock,
  input logic     iReset,
  gb_bus_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, RD, WR} dmaState_t;

  logic [7:0] rCartridgeBank0 [0:16383];
  logic [7:0] rvMem           [0:8191];
  logic [7:0] rWram           [0:8191];
  logic [7:0] rOam            [0:159];
  logic [7:0] rIo             [0:127];
  logic [7:0] rHram           [0:126];
  logic [7:0] rIe;
`ifdef GB_BOOTROM_OVERLAY_EN
  logic [7:0] rBootRom        [0:255];
  logic       rBootEn;
`endif

  dmaState_t  rState;
  logic       rBusy;
  logic [7:0] rDmaSrc;
  logic [7:0] rDmaIdx;
  logic [7:0] rDmaByte;
  logic [7:0] rDlyCnt;
  logic [7:0] rData;

  logic       inHram;
  logic       cpuWeOk;
  logic       ff46Write;
  logic       dmaOamWe;
  logic [7:0] cpuRd;
  logic [7:0] dmaRd;

  // Plain address-map decode shared by the CPU read port and the DMA source read.
  function automatic logic [7:0] memRead(input logic [15:0] a);
    logic [7:0] d;
    d = 8'hFF;
    if (a < 16'h4000)       d = rCartridgeBank0[a[13:0]];
    else if (a < 16'h8000)  d = 8'hFF;
    else if (a < 16'hA000)  d = rvMem[a[12:0]];
    else if (a < 16'hC000)  d = 8'hFF;
    else if (a < 16'hFE00)  d = rWram[a[12:0]];   // C000-DFFF and echo E000-FDFF share a[12:0]
    else if (a < 16'hFEA0)  d = rOam[a[7:0]];
    else if (a < 16'hFF00)  d = 8'h00;
    else if (a < 16'hFF80)  d = rIo[a[6:0]];
    else if (a != 16'hFFFF) d = rHram[a[6:0]];
    else                    d = rIe;
`ifdef GB_BOOTROM_OVERLAY_EN
    if (rBootEn && a < 16'h0100) d = rBootRom[a[7:0]];
    if (a == 16'hFF50)           d = 8'hFF;
`endif
    return d;
  endfunction

  assign inHram    = (bus.iAddr >= 16'hFF80) && (bus.iAddr != 16'hFFFF);
  // While DMA runs only HRAM and the DMA register itself stay reachable.
  assign cpuWeOk   = bus.iWe && (!rBusy || inHram || bus.iAddr == 16'hFF46);
  assign ff46Write = cpuWeOk && (bus.iAddr == 16'hFF46);
  // A restart in the same cycle as a copy step wins: that step's OAM write is dropped.
  assign dmaOamWe  = (rState == WR) && !ff46Write;
  assign dmaRd     = memRead({rDmaSrc, rDmaIdx});

  always_comb begin
    cpuRd = memRead(bus.iAddr);
    if (rBusy && !(inHram || bus.iAddr == 16'hFF46)) cpuRd = 8'hFF;
  end

  assign bus.oData    = rData;
  assign bus.oDmaBusy = rBusy;

  // Memory arrays: no reset.
  always_ff @(posedge iClock) begin
    if (cpuWeOk) begin
      if (bus.iAddr >= 16'h8000 && bus.iAddr < 16'hA000) rvMem[bus.iAddr[12:0]] <= bus.iData;
      if (bus.iAddr >= 16'hC000 && bus.iAddr < 16'hFE00) rWram[bus.iAddr[12:0]] <= bus.iData;
      if (bus.iAddr >= 16'hFE00 && bus.iAddr < 16'hFEA0) rOam[bus.iAddr[7:0]] <= bus.iData;
      if (inHram) rHram[bus.iAddr[6:0]] <= bus.iData;
    end
    if (dmaOamWe) rOam[rDmaIdx] <= rDmaByte;
  end

  // Registers, read port and DMA sequencer.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rData    <= 8'hFF;
      rState   <= IDLE;
      rBusy    <= 1'b0;
      rDmaSrc  <= 8'h00;
      rDmaIdx  <= 8'h00;
      rDmaByte <= 8'h00;
      rDlyCnt  <= 8'h00;
      rIe      <= 8'h00;
      for (int i = 0; i < 128; i++) rIo[i] <= 8'h00;
`ifdef GB_BOOTROM_OVERLAY_EN
      rBootEn  <= 1'b1;
`endif
    end else begin
      rData <= cpuRd;

`ifdef GB_BOOTROM_OVERLAY_EN
      if (cpuWeOk && bus.iAddr >= 16'hFF00 && bus.iAddr < 16'hFF80 && bus.iAddr != 16'hFF50)
        rIo[bus.iAddr[6:0]] <= bus.iData;
      if (cpuWeOk && bus.iAddr == 16'hFF50 && bus.iData != 8'h00) rBootEn <= 1'b0;
`else
      if (cpuWeOk && bus.iAddr >= 16'hFF00 && bus.iAddr < 16'hFF80)
        rIo[bus.iAddr[6:0]] <= bus.iData;
`endif
      if (cpuWeOk && bus.iAddr == 16'hFFFF) rIe <= bus.iData;

      if (ff46Write) begin
        rState  <= START;
        rBusy   <= 1'b1;
        rDmaIdx <= 8'h00;
        rDlyCnt <= 8'h00;
        // E0-FF source pages fold onto WRAM through the echo region.
        rDmaSrc <= (bus.iData >= 8'hE0) ? (bus.iData - 8'h20) : bus.iData;
      end else begin
        case (rState)
          IDLE: ;
          START: begin
            if (rDlyCnt == 8'(DMA_START_DLY - 1)) rState <= RD;
            else rDlyCnt <= rDlyCnt + 8'h01;
          end
          RD: begin
            rDmaByte <= dmaRd;
            rState   <= WR;
          end
          WR: begin
            rDmaIdx <= rDmaIdx + 8'h01;
            if (rDmaIdx == 8'(DMA_LEN - 1)) begin
              rState <= IDLE;
              rBusy  <= 1'b0;
            end else begin
              rState <= RD;
            end
          end
          default: rState <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_bus_responder.sv
// tb/tb_gb_bus_responder.sv - scoreboard bench for gb_bus_responder
// Reads push their expected byte into a queue; a monitor pops and compares oData
// one cycle later. DMA busy timing and async reset are checked directly.
module tb_gb_bus_responder;
  logic iClock;
  logic iReset;
  int   tests  = 0;
  int   failed = 0;
  logic rdIssue = 1'b0;

  logic [7:0] expQ[$];
  string      nameQ[$];

  gb_bus_if bus();

  gb_bus_responder dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", n, got, exp);
    end
  endtask

  // Monitor: the read data for a read issued before this edge is valid after it.
  always @(posedge iClock) begin
    if (rdIssue) begin
      @(negedge iClock);
      tests++;
      if (expQ.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty: got %0h required queued entry", bus.oData);
      end else begin
        logic [7:0] e;
        string      n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        if (bus.oData !== e) begin
          failed++;
          $display("FAIL %s: got %0h required %0h", n, bus.oData, e);
        end
      end
    end
  end

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
    @(posedge iClock); #1;
    bus.iAddr = a;
    bus.iWe   = 1'b0;
    expQ.push_back(e);
    nameQ.push_back(n);
    rdIssue = 1'b1;
    @(posedge iClock); #1;
    rdIssue = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge iClock); #1;
    bus.iAddr = a;
    bus.iData = d;
    bus.iWe   = 1'b1;
    @(posedge iClock); #1;
    bus.iWe   = 1'b0;
  endtask

  task automatic countBusy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iClock);
      if (bus.oDmaBusy) cnt++;
      else break;
    end
  endtask

  initial begin
    int cnt;
    iReset    = 1'b1;
    bus.iAddr = 16'h0101;
    bus.iData = 8'h00;
    bus.iWe   = 1'b0;
    dut.rCartridgeBank0[16'h0101] = 8'hC3;
    dut.rCartridgeBank0[16'h0000] = 8'h00;
`ifdef GB_BOOTROM_OVERLAY_EN
    dut.rBootRom[0] = 8'h31;
`endif
    repeat (3) @(negedge iClock);
    check("reset_odata", bus.oData, 8'hFF);
    check("reset_busy", bus.oDmaBusy, 1'b0);
    @(posedge iClock); #1;
    iReset = 1'b0;

    // Reset state and basic map
    rd(16'h0101, 8'hC3, "rom_0101");
    rd(16'hFF10, 8'h00, "io_reset");
    rd(16'hFFFF, 8'h00, "ie_reset");
    wr(16'h0101, 8'h00);
    rd(16'h0101, 8'hC3, "rom_write_ignored");
    wr(16'hC123, 8'h5A);
    rd(16'hE123, 8'h5A, "echo_e123");
    rd(16'hA000, 8'hFF, "unmapped_a000");
    rd(16'hFEA0, 8'h00, "fea0_zero");
    rd(16'h4000, 8'hFF, "bank1_ff");
    wr(16'hFF01, 8'hAA);
    rd(16'hFF01, 8'hAA, "io_readback");
    wr(16'hFFFF, 8'h1F);
    rd(16'hFFFF, 8'h1F, "ie_readback");
    wr(16'h8010, 8'h66);
    rd(16'h8010, 8'h66, "vram_readback");

    // DMA from C000
    for (int i = 0; i < 160; i++) wr(16'(16'hC000 + i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < 160; i++) wr(16'(16'hC100 + i), 8'(i) ^ 8'h5A);
    wr(16'hFF46, 8'hC0);
    fork
      countBusy(cnt);
      begin
        rd(16'hC000, 8'hFF, "dma_block_c000");
        wr(16'hFF80, 8'h77);
        rd(16'hFF80, 8'h77, "dma_hram");
        rd(16'hFF46, 8'hC0, "dma_ff46_read");
        wr(16'hFE05, 8'h99);
      end
    join
    check("dma_busy_cycles", cnt, 321);
    rd(16'hFE00, 8'h3C, "oam_00");
    rd(16'hFE05, 8'h39, "oam_05_cpu_blocked");
    rd(16'hFE9F, 8'hA3, "oam_9f");

    // DMA restart: second write 50 cycles after the first
    wr(16'hFF46, 8'hC0);
    repeat (48) @(posedge iClock);
    wr(16'hFF46, 8'hC1);
    countBusy(cnt);
    check("restart_busy_cycles", cnt, 321);
    rd(16'hFE00, 8'h5A, "restart_oam_00");
    rd(16'hFE31, 8'h6B, "restart_oam_31");
    rd(16'hFE9F, 8'hC5, "restart_oam_9f");

    // Reset mid-DMA after 100 cycles
    wr(16'hFF46, 8'hC0);
    repeat (100) @(posedge iClock);
    #1 iReset = 1'b1;
    #1 check("abort_busy_async", bus.oDmaBusy, 1'b0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    rd(16'hFE00, 8'h3C, "abort_oam_00");
    rd(16'hFE30, 8'h0C, "abort_oam_48");
    rd(16'hFE31, 8'h6B, "abort_oam_49");
    rd(16'hFE9F, 8'hC5, "abort_oam_9f");
    rd(16'hFF46, 8'h00, "abort_io_cleared");

`ifdef GB_BOOTROM_OVERLAY_EN
    rd(16'h0000, 8'h31, "boot_on");
    wr(16'hFF50, 8'h00);
    rd(16'h0000, 8'h31, "boot_zero_write");
    wr(16'hFF50, 8'h01);
    rd(16'h0000, 8'h00, "boot_off");
    rd(16'hFF50, 8'hFF, "boot_ff50_read");
`else
    rd(16'h0000, 8'h00, "no_overlay_0000");
    wr(16'hFF50, 8'h12);
    rd(16'hFF50, 8'h12, "ff50_plain_io");
`endif

    repeat (3) @(posedge iClock);
    check("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/gb_bus_responder.md
Name: gb_bus_responder

Overview:
- Target-side responder for the DZCPU memory bus (oMCUAddr/oMCUData/oMCUwe → iMCUData).
- Decodes the 16-bit GB address map and services CPU reads and writes to ROM bank 0, VRAM, WRAM (with echo), OAM, IO register file, HRAM and IE.
- Contains the OAM DMA engine triggered by a write to FF46.
- Sits between DZCPU and the memories inside pGB; the testbench preloads memories hierarchically (rCartridgeBank0, rvMem).

Parameters:
- DMA_LEN, 160, bytes copied per OAM DMA.
- DMA_START_DLY, 1, idle cycles between the FF46 write and the first DMA read.

Ports:
- iClock  input  1  system clock, all state on posedge.
- iReset  input  1  asynchronous active-high reset.
- iAddr  input  16  CPU bus address.
- iData  input  8  CPU write data.
- iWe  input  1  CPU write strobe, one cycle per write.
- oData  output  8  registered read data, valid one cycle after iAddr.
- oDmaBusy  output  1  high while OAM DMA is active.

Behaviour:
- Reset (async, iReset=1): oData=8'hFF, oDmaBusy=0, DMA FSM→IDLE, IO regs=0, IE=0, boot overlay enabled. Memory arrays are not reset.
- Address map:
  - 0000-3FFF: rCartridgeBank0. Read-only; writes ignored.
  - 4000-7FFF: reads 8'hFF.
  - 8000-9FFF: rvMem[addr-8000], 8 KB.
  - A000-BFFF: unmapped; reads FF, writes ignored.
  - C000-DFFF: WRAM 8 KB.
  - E000-FDFF: echo of C000-DDFF, same storage.
  - FE00-FE9F: OAM 160 B.
  - FEA0-FEFF: reads 00, writes ignored.
  - FF00-FF7F: IO regfile 128 B, read-back of last write.
  - FF80-FFFE: HRAM 127 B.
  - FFFF: IE.
- Reads: oData <= decoded byte at posedge; latency exactly 1 cycle; no handshake.
- Writes: committed at the posedge where iWe=1. A same-cycle read of the same address returns the old value; the next cycle returns the new value.
- FF46 write value V:
  - Stores V in the IO regfile.
  - Source = {V,8'h00}; V>=8'hE0 maps as V-8'h20 (echo), so FE→DE and FF→DF.
- DMA FSM:
  - States: IDLE, START, RD, WR.
  - IDLE→START on FF46 write.
  - START holds DMA_START_DLY cycles, then →RD.
  - RD latches src byte into rDmaByte.
  - WR writes OAM[idx], idx++. WR→RD if idx<DMA_LEN, else →IDLE.
  - Total busy = DMA_START_DLY + 2*DMA_LEN cycles (321 by default).
  - oDmaBusy=1 in START/RD/WR.
- During DMA (oDmaBusy=1):
  - CPU reads outside FF80-FFFE and outside FF46 return FF.
  - CPU writes outside HRAM/FF46 are ignored.
  - HRAM remains fully accessible.
- FF46 write while busy: restart from idx=0 with the new source; this takes priority over the in-progress copy.
- Reset mid-DMA: immediate abort. OAM bytes already written keep their values.
- Simultaneous DMA WR and CPU write to OAM: the CPU write is dropped because it is blocked during DMA.

Optional Feature:
- Macro: GB_BOOTROM_OVERLAY_EN.
- Defined:
  - 256-byte rBootRom array.
  - While rBootEn=1, reads of 0000-00FF return rBootRom.
  - A write of any nonzero value to FF50 clears rBootEn permanently until reset. Writing 00 has no effect.
  - rBootEn reset value is 1.
  - FF50 reads return FF.
- Not defined:
  - No boot array; 0000-00FF always reads rCartridgeBank0.
  - FF50 is an ordinary IO register.

Test Plan:
1. Reset check: preload rCartridgeBank0[16'h101]=C3, release reset, iAddr=0101 → oData=C3 one cycle later; during reset oData=FF.
2. Echo check: write 5A @ C123, then read E123 → 5A; read A000 → FF; read FEA0 → 00.
3. DMA: fill C000-C09F with idx^8'h3C, write C0 @ FF46 → oDmaBusy high for exactly 321 cycles; OAM[FE00]=3C, OAM[FE9F]=A3; read C000 mid-DMA → FF; HRAM FF80 write/read of 77 → 77.
4. DMA restart: write C0 @ FF46, at cycle 50 write C1 @ FF46 → busy ends 321 cycles after the second write; OAM holds the C100-C19F data.
5. Reset mid-DMA: assert iReset at cycle 100 → oDmaBusy=0 asynchronously; OAM[0..48] updated, OAM[49..] unchanged.
6. GB_BOOTROM_OVERLAY_EN: rBootRom[0]=31, rCartridgeBank0[0]=00; read 0000 → 31; write 01 @ FF50; read 0000 → 00. Writing 00 @ FF50 beforehand leaves the overlay on.
